// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF   = 32;
   localparam int DATA_W_DEF   = 32;
   localparam int MAX_WAIT_DEF = 3;
   localparam int TIMEOUT_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store path,
// with data priority, fetch anti-starvation and a memory timeout.
//
// state | meaning
// IDLE  | no access in flight; arbitrate between i_req and d_req
// BUSY  | mem_req high, waiting for mem_ready or timeout
// DONE  | one-cycle ack (and err) to the owner; requests ignored
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   arb_state_t        state;
   arb_owner_t        owner;
   logic [WAIT_W-1:0] wait_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              wait_full;
   logic              grant_i;

   assign wait_full = (wait_cnt == WAIT_W'(MAX_WAIT));
   assign grant_i   = i_req && (!d_req || wait_full);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= OWN_I;
         wait_cnt  <= '0;
         tmo_cnt   <= '0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         err       <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_i) begin
                  owner    <= OWN_I;
                  mem_addr <= i_addr;
                  mem_we   <= 1'b0;
                  mem_req  <= 1'b1;
                  tmo_cnt  <= '0;
                  wait_cnt <= '0;
                  state    <= BUSY;
               end else if (d_req) begin
                  owner     <= OWN_D;
                  mem_addr  <= d_addr;
                  mem_we    <= d_we;
                  mem_wdata <= d_wdata;
                  mem_req   <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= BUSY;
                  // Only count data grants that actually held off a fetch.
                  if (i_req && !wait_full) begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  if (owner == OWN_I) begin
                     i_rdata <= mem_rdata;
                     i_ack   <= 1'b1;
                  end else begin
                     if (!mem_we) begin
                        d_rdata <= mem_rdata;
                     end
                     d_ack <= 1'b1;
                  end
                  err     <= 1'b0;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= DONE;
               end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                  if (owner == OWN_I) begin
                     i_rdata <= '0;
                     i_ack   <= 1'b1;
                  end else begin
                     if (!mem_we) begin
                        d_rdata <= '0;
                     end
                     d_ack <= 1'b1;
                  end
                  err     <= 1'b1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            DONE: begin
               i_ack <= 1'b0;
               d_ack <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
